// File: rtl/gearbox_pkg.sv
// Shared constants, state encoding and helpers for the 66b->16b transmit gearbox.
package gearbox_pkg;

  localparam int DATA_W       = 64;
  localparam int HDR_W        = 2;
  localparam int OUT_W        = 16;
  localparam int BLK_W        = DATA_W + HDR_W;
  localparam int BUF_W        = OUT_W - 1 + BLK_W;
  localparam int LVL_W        = 7;
  localparam int CNT_W        = 6;
  localparam int BLK_PER_CYC  = 8;
  localparam int WORD_PER_CYC = 33;

  localparam logic [LVL_W-1:0] OUT_LVL   = 7'd16;
  localparam logic [LVL_W-1:0] BLK_LVL   = 7'd66;
  localparam logic [LVL_W-1:0] ROOM_LVL  = 7'd15;
  localparam logic [CNT_W-1:0] CNT_LAST  = 6'd32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  function automatic logic [LVL_W-1:0] lvl_after_pop(input logic [LVL_W-1:0] lvl);
    logic [LVL_W-1:0] res;
    if (lvl >= OUT_LVL) res = lvl - OUT_LVL;
    else res = lvl;
    return res;
  endfunction

endpackage

// File: rtl/gearbox_shift_buf.sv
// Bit accumulator for the gearbox: pops the oldest 16 bits and appends a 66b block
// directly above whatever remains; owns the fill level.
module gearbox_shift_buf
  import gearbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  input  logic             push,
  input  logic [BLK_W-1:0] blk,
  output logic [OUT_W-1:0] head,
  output logic [LVL_W-1:0] level
);

  logic [BUF_W-1:0] data_r;
  logic [BUF_W-1:0] data_next_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] base_s;
  logic [LVL_W-1:0] level_next_s;

  // A pop with fewer than 16 bits left empties the buffer; bits above level are always zero.
  always_comb begin
    data_next_s  = data_r;
    base_s       = level_r;
    level_next_s = level_r;
    if (pop) begin
      data_next_s = data_r >> OUT_W;
      base_s      = (level_r >= OUT_LVL) ? (level_r - OUT_LVL) : 7'd0;
    end else begin
      base_s = level_r;
    end
    if (push) begin
      data_next_s  = data_next_s | ({{(BUF_W-BLK_W){1'b0}}, blk} << base_s);
      level_next_s = base_s + BLK_LVL;
    end else begin
      level_next_s = base_s;
    end
  end

  // Buffer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      level_r <= 7'd0;
    end else begin
      data_r  <= data_next_s;
      level_r <= level_next_s;
    end
  end

  assign head  = data_r[OUT_W-1:0];
  assign level = level_r;

endmodule

// File: rtl/gearbox_tx_sched.sv
// Transmit scheduler for the 66b->16b gearbox: block handshake, run/drain control,
// 33-word alignment counter and registered word output.
module gearbox_tx_sched
  import gearbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HDR_W-1:0]  in_syn,
  input  logic [DATA_W-1:0] in_data,
  output logic [OUT_W-1:0]  op,
  output logic              op_valid,
  output logic              sof,
  output logic              underrun,
  output logic [LVL_W-1:0]  level
);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [OUT_W-1:0] head_s;
  logic             full_s;
  logic             emit_s;
  logic             acc_s;

  assign full_s   = (level >= OUT_LVL);
  assign in_ready = (state_r == ST_RUN) && (lvl_after_pop(level) <= ROOM_LVL);
  assign acc_s    = in_valid && in_ready;

  // Word emission: full words in RUN and DRAIN, plus the zero-padded residue in DRAIN.
  always_comb begin
    emit_s = 1'b0;
    case (state_r)
      ST_RUN:   emit_s = full_s;
      ST_DRAIN: emit_s = (level != 7'd0);
      default:  emit_s = 1'b0;
    endcase
  end

  // Run/drain control; en is only sampled again once the drain reaches IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = en ? ST_RUN : ST_IDLE;
      ST_RUN:   state_next_s = en ? ST_RUN : ST_DRAIN;
      ST_DRAIN: state_next_s = (level == 7'd0) ? ST_IDLE : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  gearbox_shift_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .pop   (emit_s),
    .push  (acc_s),
    .blk   ({in_data, in_syn}),
    .head  (head_s),
    .level (level)
  );

  // State, alignment counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      op       <= 16'h0000;
      op_valid <= 1'b0;
      sof      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      op_valid <= emit_s;
      sof      <= emit_s && (cnt_r == 6'd0);
      underrun <= (state_r == ST_RUN) && !full_s;
      if (emit_s) op <= head_s;
      if ((state_r == ST_IDLE) && en) cnt_r <= 6'd0;
      else if (emit_s) cnt_r <= (cnt_r == CNT_LAST) ? 6'd0 : (cnt_r + 6'd1);
    end
  end

endmodule

// File: tb/tb_gearbox_tx_sched.sv
// Self-checking bench for gearbox_tx_sched: directed table, multi-cycle corner sequences
// and randomized traffic against a bit-queue reference model.
module tb_gearbox_tx_sched;
  import gearbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_syn = 2'b00;
  logic [63:0] in_data = 64'h0;
  logic [15:0] op;
  logic        op_valid;
  logic        sof;
  logic        underrun;
  logic [6:0]  level;

  gearbox_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_syn(in_syn), .in_data(in_data), .op(op), .op_valid(op_valid), .sof(sof),
    .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of pending bits, earliest bit at the front.
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
  bit   mq[$];
  int   mstate = M_IDLE;
  int   mcnt = 0;
  logic pre_ready;
  bit   last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mstate = M_IDLE;
    mcnt = 0;
  endtask

  // One clock: drive, check combinational handshake, advance model, check registered outputs.
  task automatic step(input logic en_v, input logic val_v, input logic [1:0] syn_v, input logic [63:0] data_v);
    int lvl;
    bit exp_ready, acc, emit, exp_uf, exp_sof;
    logic [15:0] w;
    en = en_v; in_valid = val_v; in_syn = syn_v; in_data = data_v;
    #1;
    lvl = mq.size();
    exp_ready = (mstate == M_RUN) && (((lvl >= 16) ? lvl - 16 : lvl) <= 15);
    pre_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("level_pre", 64'(level), 64'(lvl));
    acc = val_v && exp_ready;
    emit = ((mstate == M_RUN) && (lvl >= 16)) || ((mstate == M_DRAIN) && (lvl > 0));
    exp_uf = (mstate == M_RUN) && (lvl < 16);
    exp_sof = emit && (mcnt == 0);
    w = 16'h0000;
    if (emit) begin
      for (int b = 0; b < 16; b++) if (mq.size() > 0) w[b] = mq.pop_front();
      mcnt = (mcnt + 1) % WORD_PER_CYC;
    end
    if (acc) begin
      for (int b = 0; b < 2; b++) mq.push_back(syn_v[b]);
      for (int b = 0; b < 64; b++) mq.push_back(data_v[b]);
    end
    case (mstate)
      M_IDLE:  if (en_v) begin mstate = M_RUN; mcnt = 0; end
      M_RUN:   if (!en_v) mstate = M_DRAIN;
      default: if (lvl == 0) mstate = M_IDLE;
    endcase
    last_acc = acc;
    @(posedge clk); #1;
    chk("op_valid", 64'(op_valid), 64'(emit));
    if (emit) chk("op", 64'(op), 64'(w));
    chk("underrun", 64'(underrun), 64'(exp_uf));
    chk("sof", 64'(sof), 64'(exp_sof));
    chk("level", 64'(level), 64'(mq.size()));
    chk("level_max", 64'(level <= 7'd81), 64'd1);
  endtask

  task automatic reach_level(input int target);
    int n = 0;
    while (mq.size() != target && n < 300) begin
      step(1'b1, (mq.size() < 16), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      n++;
    end
    chk("reach_level", 64'(level), 64'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic        val;
    logic        rdy;
    logic        ov;
    logic [15:0] op;
    logic        uf;
    logic        sof;
    logic [6:0]  lvl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, words, uf_cnt, sof_cnt, widx;
    // One block syn=01 data=0123456789ABCDEF, then drain of the 2-bit residue.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 7'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 7'd66};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h37BD, 1'b0, 1'b1, 7'd50};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h26AF, 1'b0, 1'b0, 7'd34};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h159E, 1'b0, 1'b0, 7'd18};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h048D, 1'b0, 1'b0, 7'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 7'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 7'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 7'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 7'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 7'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 7'd0};

    rst_n = 1'b0;
    #2;
    chk("rst_op", 64'(op), 64'h0);
    chk("rst_op_valid", 64'(op_valid), 64'h0);
    chk("rst_sof", 64'(sof), 64'h0);
    chk("rst_underrun", 64'(underrun), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].val, 2'b01, 64'h0123456789ABCDEF);
      chk($sformatf("tbl%0d_ready", i), 64'(pre_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_ov", i), 64'(op_valid), 64'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_op", i), 64'(op), 64'(tbl[i].op));
      chk($sformatf("tbl%0d_uf", i), 64'(underrun), 64'(tbl[i].uf));
      chk($sformatf("tbl%0d_sof", i), 64'(sof), 64'(tbl[i].sof));
      chk($sformatf("tbl%0d_lvl", i), 64'(level), 64'(tbl[i].lvl));
      if (i == 10) chk("tbl_idle", 64'(dut.state_r), 64'(ST_IDLE));
    end

    // Sustained in_valid: 8 handshakes and 33 back-to-back words per alignment cycle.
    hs = 0; words = 0; uf_cnt = 0; sof_cnt = 0; widx = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom});
      if (i < 33 && pre_ready) hs++;
      if (i >= 1 && i <= 33 && op_valid) words++;
      if (i >= 1 && underrun) uf_cnt++;
      if (op_valid) begin
        if (widx <= 33) begin
          if (sof) sof_cnt++;
          if (widx == 0 || widx == 33) chk("t3_sof_word", 64'(sof), 64'd1);
        end
        widx++;
      end
    end
    chk("t3_handshakes", 64'(hs), 64'd8);
    chk("t3_words", 64'(words), 64'd33);
    chk("t3_underrun", 64'(uf_cnt), 64'd0);
    chk("t3_sof_count", 64'(sof_cnt), 64'd2);

    // Pop and accept in the same cycle at level 16.
    reach_level(16);
    step(1'b1, 1'b1, 2'b10, {$urandom, $urandom});
    chk("t5_ready", 64'(pre_ready), 64'd1);
    chk("t5_accept", 64'(last_acc), 64'd1);
    chk("t5_op_valid", 64'(op_valid), 64'd1);
    chk("t5_level", 64'(level), 64'd66);

    // Drain from level 40 with en re-raised mid-drain.
    reach_level(40);
    step(1'b0, 1'b0, 2'b00, 64'h0);
    chk("t6_w1", 64'(op_valid), 64'd1);
    chk("t6_lvl1", 64'(level), 64'd24);
    step(1'b1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_w2", 64'(op_valid), 64'd1);
    chk("t6_drain_hold", 64'(dut.state_r), 64'(ST_DRAIN));
    step(1'b1, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_w3", 64'(op_valid), 64'd1);
    chk("t6_pad", 64'(op[15:8]), 64'h0);
    chk("t6_lvl3", 64'(level), 64'd0);
    chk("t6_uf", 64'(underrun), 64'd0);
    step(1'b1, 1'b0, 2'b00, 64'h0);
    chk("t6_idle", 64'(dut.state_r), 64'(ST_IDLE));
    chk("t6_no_word", 64'(op_valid), 64'd0);
    step(1'b1, 1'b0, 2'b00, 64'h0);

    // Asynchronous reset mid-RUN at level 50.
    reach_level(50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_op", 64'(op), 64'h0);
    chk("t1_op_valid", 64'(op_valid), 64'h0);
    chk("t1_in_ready", 64'(in_ready), 64'h0);
    chk("t1_level", 64'(level), 64'h0);
    model_reset();
    en = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_idle", 64'(dut.state_r), 64'(ST_IDLE));

    // Randomized traffic with occasional drains.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 94), ($urandom_range(0, 99) < 70),
           2'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
